// File: rtl/add_round_key_stage_if.sv
// add_round_key_stage_if
//   Word stream for the AddRoundKey stage: an upstream channel carrying a state
//   word plus its key selector, and a downstream channel carrying the result.
//   Both channels use valid/ready handshakes.
//   Signals:
//     in_valid/in_ready          upstream handshake
//     in_data                    state word
//     in_key_idx                 round-key slot to apply
//     in_bypass                  pass in_data through untouched
//     out_valid/out_ready        downstream handshake
//     out_data                   result word
//   Modports:
//     master  drives the upstream word and accepts results (round logic / bench)
//     slave   the stage itself
interface add_round_key_stage_if #(
  parameter int DATA_W = 128,
  parameter int IDX_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [IDX_W-1:0]  in_key_idx;
  logic              in_bypass;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_key_idx, in_bypass, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key_idx, in_bypass, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/add_round_key_stage.sv
// add_round_key_stage
//   AES AddRoundKey stage. Holds NUM_KEYS round keys written through a simple
//   write port. Each accepted word is XORed with the key in the slot it names
//   (or passed through when bypassed) and queued in a 2-entry output FIFO so
//   upstream and downstream round logic can stall independently.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     key_wr_en     write key_wr_data into slot key_wr_idx (ignored if idx out of range)
//     key_wr_idx    key slot to write
//     key_wr_data   round key value
//     bus           word stream (slave side), see add_round_key_stage_if
//     key_loaded    bit i set once slot i has been written since reset
//     err           sticky: a non-bypassed word named an invalid or unloaded slot
//   2**IDX_W must be >= NUM_KEYS; DATA_W must be a multiple of LANE_W.

// One byte lane of the XOR datapath.
module ark_lane #(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W-1:0] data,
  input  logic [LANE_W-1:0] key,
  input  logic              key_en,
  output logic [LANE_W-1:0] res
);
  assign res = key_en ? (data ^ key) : data;
endmodule

module add_round_key_stage #(
  parameter int DATA_W   = 128,
  parameter int NUM_KEYS = 11,
  parameter int IDX_W    = 4,
  parameter int LANE_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_wr_en,
  input  logic [IDX_W-1:0]    key_wr_idx,
  input  logic [DATA_W-1:0]   key_wr_data,
  add_round_key_stage_if.slave bus,
  output logic [NUM_KEYS-1:0] key_loaded,
  output logic                err
);
  localparam int NUM_LANES = DATA_W / LANE_W;

  // ---------------- key bank ----------------
  logic [NUM_KEYS-1:0][DATA_W-1:0] keys;

  // Slot match by equality against each legal index: an out-of-range
  // key_wr_idx matches nothing and the write falls away with no side effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      keys       <= '0;
      key_loaded <= '0;
    end else if (key_wr_en) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_wr_idx == IDX_W'(i)) begin
          keys[i]       <= key_wr_data;
          key_loaded[i] <= 1'b1;
        end
      end
    end
  end

  // Read side sees the pre-edge slot contents, so a same-cycle write to the
  // slot being used only affects later words.
  logic [DATA_W-1:0] key_sel;
  logic              slot_ok;

  always_comb begin
    key_sel = '0;
    slot_ok = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (bus.in_key_idx == IDX_W'(i)) begin
        key_sel = keys[i];
        slot_ok = key_loaded[i];
      end
    end
  end

  // ---------------- XOR datapath ----------------
  logic                             key_en;
  logic [NUM_LANES-1:0][LANE_W-1:0] data_lanes;
  logic [NUM_LANES-1:0][LANE_W-1:0] key_lanes;
  logic [NUM_LANES-1:0][LANE_W-1:0] res_lanes;
  logic [DATA_W-1:0]                res;

  // Invalid or unloaded slot degrades to pass-through (and flags err).
  assign key_en     = !bus.in_bypass && slot_ok;
  assign data_lanes = bus.in_data;
  assign key_lanes  = key_sel;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    ark_lane #(.LANE_W(LANE_W)) u_lane (
      .data   (data_lanes[l]),
      .key    (key_lanes[l]),
      .key_en (key_en),
      .res    (res_lanes[l])
    );
  end

  assign res = res_lanes;

  // ---------------- output FIFO ----------------
  // head is the registered out_data; tail only holds the second word when
  // full. Keeping head as its own register lets out_data keep its last value
  // when the FIFO drains.
  logic [1:0]        count;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;
  logic              push;
  logic              pop;

  // in_ready comes from count alone: no path from out_ready.
  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = head;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head  <= res;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= res;
          end else if (push) begin
            tail  <= res;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            head  <= tail;
            count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

  // ---------------- sticky error ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (push && !bus.in_bypass && !slot_ok) begin
      err <= 1'b1;
    end
  end
endmodule

// File: doc/add_round_key_stage.md
Name: add_round_key_stage

Overview:
Parametrised, handshaked AddRoundKey stage for the AES datapath. It holds a bank of round keys that are loaded through a write port. It XORs each accepted state word with the round key named by its index, or passes the word through in bypass mode. Results are buffered in a 2-entry output FIFO so that upstream and downstream round logic can stall independently.

Parameters:
DATA_W, 128, width of the state word and of each round key.
NUM_KEYS, 11, number of round-key slots (AES-128 uses rounds 0..10).
IDX_W, 4, key index width; 2**IDX_W >= NUM_KEYS is required.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous reset, active-high.
key_wr_en  in  1  write key_wr_data into slot key_wr_idx.
key_wr_idx  in  IDX_W  key slot to write.
key_wr_data  in  DATA_W  round key value.
in_valid  in  1  upstream word valid.
in_ready  out  1  stage can accept a word this cycle.
in_data  in  DATA_W  state word.
in_key_idx  in  IDX_W  round key slot to apply.
in_bypass  in  1  1 = pass in_data unchanged; no key is used.
out_valid  out  1  out_data holds a result.
out_ready  in  1  downstream accepts the result.
out_data  out  DATA_W  result word.
key_loaded  out  NUM_KEYS  bit i = slot i written since reset.
err  out  1  sticky flag: a word used an invalid or unloaded key.

Behaviour:
- Reset: one clock, synchronous, active-high. On rst, all key slots and key_loaded go to 0, the FIFO is flushed, and out_valid=0, out_data=0, err=0. in_ready=1 from the first cycle after rst deasserts. Reset mid-operation discards buffered words and all keys.
- Key write:
  - If key_wr_en and key_wr_idx < NUM_KEYS: slot and key_loaded bit update at the edge.
  - If key_wr_idx >= NUM_KEYS: the write is ignored, and err is unchanged.
  - Keys may be written at any time, including while words are in flight.
- Accept: accept = in_valid & in_ready. in_ready = (count < 2) and depends only on registered state, with no combinational path from out_ready.
- Compute, on accept:
  - in_bypass=1: result = in_data.
  - in_key_idx < NUM_KEYS and the slot is loaded: result = in_data ^ key[in_key_idx].
  - Otherwise: result = in_data, and err is set to 1 at the same edge.
  - The key value used is the slot contents before that edge. A same-cycle write to the same slot affects only later words.
- Latency: a word accepted at edge N appears on out_data with out_valid=1 after edge N (1 cycle), provided the FIFO was empty.
- FIFO: 2 entries, count in 0..2, in-order.
  - Pop = out_valid & out_ready.
  - Push and pop in the same cycle: count unchanged, order preserved. This holds when full: pop frees a slot, but in_ready was already 0, so no push happens.
  - out_valid = (count != 0); out_data = head entry.
  - While out_valid=1 and out_ready=0, out_data and out_valid stay stable.
- err: sticky; cleared only by rst.
- No arithmetic other than a bitwise XOR of DATA_W bits; no carries or truncation.
- out_data is don't-care-free: when count=0 it holds its last value (0 after reset).

Test Plan:
1. FIPS-197 round 0: write slot 0 = 000102030405060708090a0b0c0d0e0f; send in_data = 00112233445566778899aabbccddeeff, idx 0, out_ready=1 -> one cycle later out_valid=1, out_data = 00102030405060708090a0b0c0d0e0f0, err=0, key_loaded=0x001.
2. Backpressure: hold out_ready=0 and offer 3 words back-to-back -> in_ready drops after the 2nd accept, out_data stays on word 1 unchanged. Raise out_ready -> words 1, 2, 3 emerge in order, one per cycle, no loss or duplication.
3. Full with simultaneous events: FIFO full, out_ready=1, in_valid=1 -> pop only that cycle, with count going 2->1. Next cycle in_ready=1; push and pop together keep count at 1.
4. Errors: send idx=5 to an unloaded slot, then idx=12 (NUM_KEYS=11), each with in_data=A5A5...A5 -> both outputs are A5A5...A5 and err latches 1. Write key_wr_idx=13 -> key_loaded unchanged. Bypass word with idx=12 -> passes through.
5. Write/read collision: slot 3 = K1. In the same cycle write slot 3 = K2 and accept a word with idx 3 -> result uses K1; the next word with idx 3 uses K2.
6. Reset mid-stream: 2 words buffered, keys loaded; assert rst for one cycle -> out_valid=0, out_data=0, key_loaded=0, err=0, in_ready=1 next cycle; a word with idx 0 then sets err=1.
